// File: rtl/wam_mol.sv
// Whac-A-Mole mole generator and hit judge: LFSR-driven spawning, per-hole
// lifetime counters, and registered hit/miss/pop event pulses.
module wam_mol #(
    parameter int          NHOLE = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk_19,
    input  logic             clr_n,
    input  logic             tick,
    input  logic             en,
    input  logic [3:0]       age,
    input  logic [7:0]       rto,
    input  logic [NHOLE-1:0] hit,
    output logic [NHOLE-1:0] mole,
    output logic             hit_ok,
    output logic             hit_bad,
    output logic             miss,
    output logic             pop
);

    localparam int          IW        = $clog2(NHOLE);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    logic [15:0]      lfsr_r;
    logic [15:0]      lfsr_nxt_s;
    logic [3:0]       life_r     [NHOLE];
    logic [3:0]       life_nxt_s [NHOLE];
    logic [IW-1:0]    idx_s;
    logic [7:0]       roll_s;
    logic             spawn_s;
    logic             ok_s;
    logic             bad_s;
    logic             miss_s;
    logic [NHOLE-1:0] mole_nxt_s;

    // Galois right-shift step; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Candidate hole, spawn roll and spawn decision from the current LFSR state.
    always_comb begin
        lfsr_nxt_s = lfsr_step(lfsr_r);
        idx_s      = lfsr_r[IW-1:0];
        roll_s     = {1'b0, lfsr_r[14:8]};
        if (en && tick && (life_r[idx_s] == 4'd0) && (age != 4'd0) && (roll_s < rto)) begin
            spawn_s = 1'b1;
        end else begin
            spawn_s = 1'b0;
        end
    end

    // Per-hole next life and aggregated event flags; a hit beats a tick expiry.
    always_comb begin
        ok_s       = 1'b0;
        bad_s      = 1'b0;
        miss_s     = 1'b0;
        mole_nxt_s = '0;
        for (int i = 0; i < NHOLE; i++) begin
            life_nxt_s[i] = life_r[i];
            if (!en) begin
                life_nxt_s[i] = 4'd0;
            end else if (hit[i] && (life_r[i] != 4'd0)) begin
                life_nxt_s[i] = 4'd0;
                ok_s          = 1'b1;
            end else if (hit[i]) begin
                bad_s = 1'b1;
            end else if (tick && (life_r[i] != 4'd0)) begin
                life_nxt_s[i] = life_r[i] - 4'd1;
                if (life_r[i] == 4'd1) begin
                    miss_s = 1'b1;
                end else begin
                    miss_s = miss_s;
                end
            end else begin
                life_nxt_s[i] = life_r[i];
            end
            if (spawn_s && (idx_s == IW'(i))) begin
                life_nxt_s[i] = age;
            end else begin
                life_nxt_s[i] = life_nxt_s[i];
            end
            mole_nxt_s[i] = (life_nxt_s[i] != 4'd0);
        end
    end

    // LFSR free-runs regardless of en and tick.
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_nxt_s;
        end
    end

    // Lifetime counters, lit-hole outputs and one-cycle event pulses.
    always_ff @(posedge clk_19 or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NHOLE; i++) begin
                life_r[i] <= 4'd0;
            end
            mole    <= '0;
            hit_ok  <= 1'b0;
            hit_bad <= 1'b0;
            miss    <= 1'b0;
            pop     <= 1'b0;
        end else begin
            for (int i = 0; i < NHOLE; i++) begin
                life_r[i] <= life_nxt_s[i];
            end
            mole    <= mole_nxt_s;
            hit_ok  <= en & ok_s;
            hit_bad <= en & bad_s;
            miss    <= en & miss_s;
            pop     <= spawn_s;
        end
    end

endmodule

// File: tb/tb_wam_mol.sv
// Randomized self-checking bench for wam_mol against a per-hole lifetime model.
module tb_wam_mol;

    localparam int NH = 8;

    logic          clk_19 = 1'b0;
    logic          clr_n;
    logic          tick;
    logic          en;
    logic [3:0]    age;
    logic [7:0]    rto;
    logic [NH-1:0] hit;
    logic [NH-1:0] mole;
    logic          hit_ok, hit_bad, miss, pop;

    int          errors = 0;
    int          checks = 0;
    int          m_life [NH];
    logic [15:0] m_lfsr;
    logic        e_ok, e_bad, e_miss, e_pop;

    wam_mol #(.NHOLE(NH), .SEED(16'hACE1)) dut (
        .clk_19(clk_19), .clr_n(clr_n), .tick(tick), .en(en), .age(age), .rto(rto),
        .hit(hit), .mole(mole), .hit_ok(hit_ok), .hit_bad(hit_bad), .miss(miss), .pop(pop)
    );

    always #5 clk_19 = ~clk_19;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NH-1:0] model_lit();
        logic [NH-1:0] v;
        for (int i = 0; i < NH; i++) v[i] = (m_life[i] != 0);
        return v;
    endfunction

    function automatic int count_lit();
        int n = 0;
        for (int i = 0; i < NH; i++) if (m_life[i] != 0) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NH; i++) m_life[i] = 0;
        m_lfsr = 16'hACE1;
        {e_ok, e_bad, e_miss, e_pop} = 4'b0000;
    endtask

    // Game rules applied to the state as it was before the clock edge.
    task automatic model_update(input logic t, input logic e, input logic [NH-1:0] h);
        int pre [NH];
        int idx, roll;
        pre = m_life;
        {e_ok, e_bad, e_miss, e_pop} = 4'b0000;
        idx  = int'(m_lfsr) % NH;
        roll = (int'(m_lfsr) / 256) % 128;
        if (!e) begin
            for (int i = 0; i < NH; i++) m_life[i] = 0;
        end else begin
            for (int i = 0; i < NH; i++) begin
                if (h[i] && pre[i] != 0) begin
                    m_life[i] = 0; e_ok = 1'b1;
                end else if (h[i]) begin
                    e_bad = 1'b1;
                end else if (t && pre[i] != 0) begin
                    m_life[i] = pre[i] - 1;
                    if (m_life[i] == 0) e_miss = 1'b1;
                end
            end
            if (t && age != 4'd0 && pre[idx] == 0 && roll < int'(rto)) begin
                m_life[idx] = int'(age); e_pop = 1'b1;
            end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    endtask

    // One clock: drive inputs, let the edge happen, compare against the model.
    task automatic step(input logic t, input logic e, input logic [NH-1:0] h);
        tick = t; en = e; hit = h;
        @(posedge clk_19);
        model_update(t, e, h);
        #1;
        check_eq("mole", mole, model_lit());
        check_eq("pulses", {hit_ok, hit_bad, miss, pop}, {e_ok, e_bad, e_miss, e_pop});
    endtask

    function automatic logic [NH-1:0] rand_hit();
        logic [NH-1:0] v = '0;
        for (int i = 0; i < NH; i++) v[i] = ($urandom_range(0, 9) == 0);
        return v;
    endfunction

    initial begin
        int a, b;
        logic [NH-1:0] lit;
        clr_n = 1'b0; tick = 1'b0; en = 1'b0; age = 4'd0; rto = 8'd0; hit = '0;
        model_reset();
        #1;
        check_eq("reset_mole", mole, '0);
        check_eq("reset_pulses", {hit_ok, hit_bad, miss, pop}, 4'b0000);
        @(posedge clk_19); #1;
        clr_n = 1'b1;

        // Mid-game reset: outputs clear without waiting for an edge.
        age = 4'd5; rto = 8'd200;
        for (int k = 0; k < 20; k++) step(1'b1, 1'b1, '0);
        clr_n = 1'b0;
        #1;
        check_eq("midreset_mole", mole, '0);
        check_eq("midreset_pulses", {hit_ok, hit_bad, miss, pop}, 4'b0000);
        @(posedge clk_19); #1;
        clr_n = 1'b1;
        model_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, '0);

        // No spawning with rto = 0.
        step(1'b0, 1'b0, '0);
        rto = 8'd0; age = 4'd7;
        for (int k = 0; k < 1000; k++) step(1'b1, 1'b1, '0);
        check_eq("nospawn_mole", mole, '0);

        // Lifetime of age 3 with no hits.
        age = 4'd3; rto = 8'd200;
        for (int k = 0; k < 40; k++) step(1'b1, 1'b1, '0);

        // Hit judging: one lit and one dark hole hit together.
        age = 4'd5;
        a = -1; b = -1;
        for (int k = 0; k < 60 && (a < 0 || b < 0); k++) begin
            step(1'b1, 1'b1, '0);
            a = -1; b = -1;
            for (int i = 0; i < NH; i++) begin
                if (m_life[i] != 0 && a < 0) a = i;
                if (m_life[i] == 0 && b < 0) b = i;
            end
        end
        if (a >= 0 && b >= 0) begin
            lit = model_lit();
            step(1'b0, 1'b1, NH'(1 << a) | NH'(1 << b));
            check_eq("judge_ok", hit_ok, 1'b1);
            check_eq("judge_bad", hit_bad, 1'b1);
            check_eq("judge_cleared", mole[a], 1'b0);
            check_eq("judge_others", mole & ~NH'(1 << a), lit & ~NH'(1 << a));
            step(1'b0, 1'b1, '0);
            check_eq("judge_one_cycle", {hit_ok, hit_bad}, 2'b00);
        end else begin
            check_eq("judge_setup", 32'(a >= 0 && b >= 0), 32'd1);
        end

        // Hit on the tick that would expire the mole: hit wins, no miss.
        age = 4'd1;
        lit = '0;
        for (int k = 0; k < 40 && lit == '0; k++) begin
            step(1'b1, 1'b1, '0);
            lit = model_lit();
        end
        step(1'b1, 1'b1, lit);
        check_eq("collide_ok", hit_ok, 32'(lit != '0));
        check_eq("collide_miss", miss, 1'b0);
        check_eq("collide_cleared", mole & lit, '0);

        // Disable with several moles lit, then resume.
        age = 4'd9; rto = 8'd200;
        for (int k = 0; k < 60 && count_lit() < 3; k++) step(1'b1, 1'b1, '0);
        check_eq("disable_setup", 32'(count_lit() >= 3), 32'd1);
        step(1'b0, 1'b0, '0);
        check_eq("disable_mole", mole, '0);
        for (int k = 0; k < 10; k++) step(1'(k % 2), 1'b0, rand_hit());
        for (int k = 0; k < 30; k++) step(1'b1, 1'b1, '0);

        // Randomized play.
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) begin
                age = 4'($urandom_range(0, 15));
                rto = 8'($urandom_range(0, 255));
            end
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 29) != 0), rand_hit());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
